pes_rca_seq: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit ripple-carry adder. It computes A + B + Cin, or A − B with borrow-in, one CHUNK-bit slice per clock, with the carry held in a register between slices. Operands enter and results leave through valid/ready handshakes, and the block reports carry-out and signed overflow. It sits in the arithmetic datapath wherever a narrow, area-cheap adder with flow control is preferred over a full-width combinational one.

---
 rtl/pes_rca_seq_if.sv | 27 ++
 rtl/pes_rca_seq.sv | 99 +++++++++
 tb/tb_pes_rca_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pes_rca_seq_if.sv
// Operand/result handshake bundle for the sequential ripple-carry adder.
// The master side presents operands and accepts results; the adder is the slave.
interface pes_rca_seq_if #(
  parameter int WIDTH = 16
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output inValid, a, b, cin, sub, outReady,
    input  inReady, outValid, sum, cout, ovf
  );

  modport slave (
    input  inValid, a, b, cin, sub, outReady,
    output inReady, outValid, sum, cout, ovf
  );
endinterface

// File: rtl/pes_rca_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with the carry
// held in a register between slices, wrapped in valid/ready handshakes.
module pes_rca_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pes_rca_seq_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             outValid_q;
  logic             inReady_q;

  logic [CHUNK:0]   slice_d;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;

  // b_q already holds the effective operand, so subtraction needs no extra logic here.
  always_comb begin
    slice_d = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
            + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
    acc_d = acc_q;
    acc_d[cnt_q*CHUNK +: CHUNK] = slice_d[CHUNK-1:0];
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inValid) begin
            a_q       <= bus.a;
            b_q       <= bus.sub ? ~bus.b : bus.b;
            carry_q   <= bus.cin ^ bus.sub;
            cnt_q     <= '0;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_d[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          // Results are only published here, so they stay frozen through DONE and IDLE.
          if (cnt_q == LAST) begin
            sum_q      <= acc_d;
            cout_q     <= slice_d[CHUNK];
            ovf_q      <= ovf_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.outReady) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // inReady is gated by reset so nothing is offered while the block is held in reset.
  assign bus.inReady  = inReady_q && !rst_i;
  assign bus.outValid = outValid_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_pes_rca_seq.sv
// Directed-vector bench for pes_rca_seq at WIDTH=16, CHUNK=4 with
// hand-computed sums, carries, overflow flags and handshake timing.
module tb_pes_rca_seq;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic clk;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;

  pes_rca_seq_if #(.WIDTH(WIDTH)) busIf ();

  pes_rca_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation, waits for the result and releases it; all checks live in the callers.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               input logic sub, output logic [15:0] sum, output logic cout,
                               output logic ovf, output int lat, output logic timedOut);
    int waitCyc;
    timedOut = 1'b0;
    lat      = 0;
    waitCyc  = 0;
    while (busIf.inReady !== 1'b1 && waitCyc < 20) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    busIf.a       = a;
    busIf.b       = b;
    busIf.cin     = cin;
    busIf.sub     = sub;
    busIf.inValid = 1'b1;
    @(posedge clk); #1;
    busIf.inValid = 1'b0;
    while (busIf.outValid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (busIf.outValid !== 1'b1) timedOut = 1'b1;
    sum  = busIf.sum;
    cout = busIf.cout;
    ovf  = busIf.ovf;
    busIf.outReady = 1'b1;
    @(posedge clk); #1;
    busIf.outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    assertCount++;
    if (busIf.inReady !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_inReady_during: got %b want 0", busIf.inReady);
    end
    assertCount++;
    if (busIf.outValid !== 1'b0 || busIf.sum !== 16'h0000 || busIf.cout !== 1'b0 || busIf.ovf !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got v=%b sum=%h c=%b o=%b want 0/0000/0/0",
               busIf.outValid, busIf.sum, busIf.cout, busIf.ovf);
    end
    rst = 1'b0;
    #1;
    assertCount++;
    if (busIf.inReady !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_inReady_after: got %b want 1", busIf.inReady);
    end
  endtask

  task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub, input logic [15:0] expSum,
                             input logic expCout, input logic expOvf);
    logic [15:0] sum;
    logic        cout, ovf, timedOut;
    int          lat;
    applyStimulus(a, b, cin, sub, sum, cout, ovf, lat, timedOut);
    assertCount++;
    if (timedOut || lat != 4) begin
      failCount++;
      $display("[TB] FAIL %s_latency: got %0d (timeout=%b) want 4", name, lat, timedOut);
    end
    assertCount++;
    if (sum !== expSum || cout !== expCout || ovf !== expOvf) begin
      failCount++;
      $display("[TB] FAIL %s_result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
               name, sum, cout, ovf, expSum, expCout, expOvf);
    end
    assertCount++;
    if (busIf.outValid !== 1'b0 || busIf.inReady !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s_release: got outValid=%b inReady=%b want 0/1",
               name, busIf.outValid, busIf.inReady);
    end
  endtask

  task automatic test_add();
    test_vector("add_basic", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h68AC, 1'b0, 1'b0);
    test_vector("add_cin",   16'hABCD, 16'h9876, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b1);
  endtask

  task automatic test_sub();
    test_vector("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_vector("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    test_vector("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    test_vector("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_boundaries();
    test_vector("bnd_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_vector("bnd_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_pressure();
    int lat;
    busIf.a = 16'h1234; busIf.b = 16'h5678; busIf.cin = 1'b0; busIf.sub = 1'b0;
    busIf.inValid = 1'b1;
    @(posedge clk); #1;
    busIf.inValid = 1'b0;
    lat = 0;
    while (busIf.outValid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    assertCount++;
    if (busIf.outValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL bp_result_timeout: got outValid=%b want 1", busIf.outValid);
    end
    busIf.a = 16'hFFFF; busIf.b = 16'hFFFF; busIf.cin = 1'b1; busIf.sub = 1'b0;
    busIf.inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      assertCount++;
      if (busIf.outValid !== 1'b1 || busIf.inReady !== 1'b0 || busIf.sum !== 16'h68AC ||
          busIf.cout !== 1'b0 || busIf.ovf !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL bp_hold_%0d: got v=%b rdy=%b sum=%h c=%b o=%b want 1/0/68ac/0/0",
                 i, busIf.outValid, busIf.inReady, busIf.sum, busIf.cout, busIf.ovf);
      end
    end
    busIf.inValid  = 1'b0;
    busIf.outReady = 1'b1;
    @(posedge clk); #1;
    busIf.outReady = 1'b0;
    assertCount++;
    if (busIf.outValid !== 1'b0 || busIf.inReady !== 1'b1 || busIf.sum !== 16'h68AC) begin
      failCount++;
      $display("[TB] FAIL bp_release: got v=%b rdy=%b sum=%h want 0/1/68ac",
               busIf.outValid, busIf.inReady, busIf.sum);
    end
    test_vector("bp_next", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    logic sawValid;
    busIf.a = 16'hFFFF; busIf.b = 16'hFFFF; busIf.cin = 1'b1; busIf.sub = 1'b0;
    busIf.inValid = 1'b1;
    @(posedge clk); #1;
    busIf.inValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    assertCount++;
    if (busIf.inReady !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_inReady_during: got %b want 0", busIf.inReady);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    assertCount++;
    if (busIf.outValid !== 1'b0 || busIf.sum !== 16'h0000 || busIf.inReady !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL rstmid_after: got v=%b sum=%h rdy=%b want 0/0000/1",
               busIf.outValid, busIf.sum, busIf.inReady);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busIf.outValid === 1'b1) sawValid = 1'b1;
    end
    assertCount++;
    if (sawValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_no_valid: got outValid pulse=%b want 0", sawValid);
    end
    test_vector("rstmid_next", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h68AC, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    busIf.inValid = 1'b0; busIf.outReady = 1'b0;
    busIf.a = '0; busIf.b = '0; busIf.cin = 1'b0; busIf.sub = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_boundaries();
    test_back_pressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
